// File: rtl/audio_io_bridge.sv
// audio_io_bridge: serial audio endpoint between an I2S/TDM codec and the DSP
// core's io memory. ADC slots are deserialized and written to IN_BASE+slot,
// DAC slots are prefetched from OUT_BASE+slot and serialized MSB-first.
// bclk, lrclk and sdin are oversampled in the core clock domain.
// Optional build macro: AUDIO_IO_ERR_CNT_EN adds a saturating 16-bit
// err_count output that counts frame_err pulses.
`timescale 1ns/1ps
module audio_io_bridge #(
   parameter int IO_WIDTH      = 24,
   parameter int IO_ADDR_WIDTH = 8,
   parameter int NUM_CHANNELS  = 8,
   parameter int SLOT_WIDTH    = 32,
   parameter int IN_BASE       = 0,
   parameter int OUT_BASE      = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i2s_bclk,
   input  logic                     i2s_lrclk,
   input  logic                     i2s_sdin,
   output logic                     i2s_sdout,
   output logic                     io_wr_en,
   output logic [IO_ADDR_WIDTH-1:0] io_wr_addr,
   output logic [IO_WIDTH-1:0]      io_wr_data,
   output logic [IO_ADDR_WIDTH-1:0] io_rd_addr,
   input  logic [IO_WIDTH-1:0]      io_rd_data,
   output logic                     frame_tick,
   output logic                     synced,
   output logic                     frame_err
`ifdef AUDIO_IO_ERR_CNT_EN
   ,
   output logic [15:0]              err_count
`endif
);

   localparam int CNT_W  = $clog2(SLOT_WIDTH);
   localparam int SLOT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   localparam logic [CNT_W-1:0]  LAST_BIT     = CNT_W'(SLOT_WIDTH - 1);
   localparam logic [CNT_W-1:0]  PREFETCH_BIT = CNT_W'(SLOT_WIDTH - 4);
   localparam logic [CNT_W-1:0]  RX_BITS      = CNT_W'(IO_WIDTH);
   localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(NUM_CHANNELS - 1);

   localparam logic [IO_ADDR_WIDTH-1:0] IN_BASE_A  = IO_ADDR_WIDTH'(IN_BASE);
   localparam logic [IO_ADDR_WIDTH-1:0] OUT_BASE_A = IO_ADDR_WIDTH'(OUT_BASE);

   // RUN: inside a frame; WAIT: full frame done, frame start due on next rise;
   // HUNT: framing lost, waiting for the next frame start.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_WAIT,
      ST_HUNT
   } state_t;

   state_t state, state_nxt;

   logic bclk_meta, bclk_sync, bclk_prev;
   logic lr_meta, lr_sync, lr_last;
   logic sd_meta, sd_sync;
   logic rise, fall, frame_start;

   logic start_frame, run_bit, err_nxt, tick_nxt;

   logic [CNT_W-1:0]    bit_cnt;
   logic [SLOT_W-1:0]   slot;
   logic [SLOT_W-1:0]   slot_inc;
   logic [IO_WIDTH-1:0] rx_shift;
   logic [IO_WIDTH-1:0] tx_shift;
   logic [IO_WIDTH-1:0] tx_next;
   logic                rd_pend1, rd_pend2;

   // Two-flop synchronizers of equal depth keep bclk, lrclk and sdin aligned.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_meta <= 1'b0;
         bclk_sync <= 1'b0;
         bclk_prev <= 1'b0;
         lr_meta   <= 1'b0;
         lr_sync   <= 1'b0;
         sd_meta   <= 1'b0;
         sd_sync   <= 1'b0;
      end else begin
         bclk_meta <= i2s_bclk;
         bclk_sync <= bclk_meta;
         bclk_prev <= bclk_sync;
         lr_meta   <= i2s_lrclk;
         lr_sync   <= lr_meta;
         sd_meta   <= i2s_sdin;
         sd_sync   <= sd_meta;
      end
   end

   assign rise        = bclk_sync & ~bclk_prev;
   assign fall        = ~bclk_sync & bclk_prev;
   assign frame_start = rise & ~lr_sync & lr_last;
   assign synced      = (state != ST_IDLE);
   assign slot_inc    = (slot == LAST_SLOT) ? '0 : slot + 1'b1;

   // Framing state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Framing decisions: frame starts, data bits, and the two malformed-frame cases.
   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      run_bit     = 1'b0;
      err_nxt     = 1'b0;
      tick_nxt    = 1'b0;
      if (rise) begin
         if (frame_start) begin
            start_frame = 1'b1;
            tick_nxt    = 1'b1;
            state_nxt   = ST_RUN;
            if (state == ST_RUN) begin
               err_nxt = 1'b1;
            end
         end else begin
            case (state)
               ST_RUN: begin
                  run_bit = 1'b1;
                  if (bit_cnt == LAST_BIT && slot == LAST_SLOT) begin
                     state_nxt = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_HUNT;
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Bit/slot counting, rx deserialization, io writes, prefetch and tx serialization.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lr_last    <= 1'b0;
         bit_cnt    <= '0;
         slot       <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         tx_next    <= '0;
         rd_pend1   <= 1'b0;
         rd_pend2   <= 1'b0;
         io_wr_en   <= 1'b0;
         io_wr_addr <= '0;
         io_wr_data <= '0;
         io_rd_addr <= OUT_BASE_A;
         i2s_sdout  <= 1'b0;
         frame_tick <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         io_wr_en   <= 1'b0;
         frame_tick <= tick_nxt;
         frame_err  <= err_nxt;
         rd_pend1   <= 1'b0;
         rd_pend2   <= rd_pend1;
         if (rd_pend2) begin
            tx_next <= io_rd_data;
         end
         if (rise) begin
            lr_last <= lr_sync;
         end
         if (start_frame) begin
            bit_cnt  <= '0;
            slot     <= '0;
            tx_shift <= tx_next;
         end else if (run_bit) begin
            if (bit_cnt < RX_BITS) begin
               rx_shift <= {rx_shift[IO_WIDTH-2:0], sd_sync};
            end
            if (bit_cnt == PREFETCH_BIT) begin
               io_rd_addr <= OUT_BASE_A + IO_ADDR_WIDTH'(slot_inc);
               rd_pend1   <= 1'b1;
            end
            if (bit_cnt == LAST_BIT) begin
               io_wr_en   <= 1'b1;
               io_wr_addr <= IN_BASE_A + IO_ADDR_WIDTH'(slot);
               io_wr_data <= rx_shift;
               bit_cnt    <= '0;
               slot       <= slot_inc;
               tx_shift   <= tx_next;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         if (fall && state != ST_IDLE) begin
            i2s_sdout <= tx_shift[IO_WIDTH-1];
            tx_shift  <= {tx_shift[IO_WIDTH-2:0], 1'b0};
         end
      end
   end

`ifdef AUDIO_IO_ERR_CNT_EN
   // Saturating count of framing errors, restarted when sync is first acquired.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (err_nxt) begin
         if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
         end
      end else if (start_frame && state == ST_IDLE) begin
         err_count <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_audio_io_bridge.sv
// tb_audio_io_bridge: directed frames driven on bclk/lrclk/sdin with an io
// memory model; expected io writes and DAC slot words go into queues that
// negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_audio_io_bridge;

   localparam int IO_WIDTH      = 24;
   localparam int IO_ADDR_WIDTH = 8;
   localparam int NUM_CHANNELS  = 8;
   localparam int SLOT_WIDTH    = 32;
   localparam int IN_BASE       = 0;
   localparam int OUT_BASE      = 8;
   localparam int HALF_BCLK     = 40;

   typedef struct packed {
      logic [IO_ADDR_WIDTH-1:0] addr;
      logic [IO_WIDTH-1:0]      data;
   } wr_item_t;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     i2s_bclk;
   logic                     i2s_lrclk;
   logic                     i2s_sdin;
   logic                     i2s_sdout;
   logic                     io_wr_en;
   logic [IO_ADDR_WIDTH-1:0] io_wr_addr;
   logic [IO_WIDTH-1:0]      io_wr_data;
   logic [IO_ADDR_WIDTH-1:0] io_rd_addr;
   logic [IO_WIDTH-1:0]      io_rd_data = '0;
   logic                     frame_tick;
   logic                     synced;
   logic                     frame_err;
`ifdef AUDIO_IO_ERR_CNT_EN
   logic [15:0]              err_count;
`endif

   wr_item_t    wr_q[$];
   logic [31:0] dac_exp_q[$];
   logic [31:0] dac_seen_q[$];

   int n_compared   = 0;
   int n_mismatched = 0;
   int wr_count     = 0;
   int tick_count   = 0;
   int err_pulses   = 0;

   audio_io_bridge #(
      .IO_WIDTH(IO_WIDTH),
      .IO_ADDR_WIDTH(IO_ADDR_WIDTH),
      .NUM_CHANNELS(NUM_CHANNELS),
      .SLOT_WIDTH(SLOT_WIDTH),
      .IN_BASE(IN_BASE),
      .OUT_BASE(OUT_BASE)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .i2s_bclk(i2s_bclk),
      .i2s_lrclk(i2s_lrclk),
      .i2s_sdin(i2s_sdin),
      .i2s_sdout(i2s_sdout),
      .io_wr_en(io_wr_en),
      .io_wr_addr(io_wr_addr),
      .io_wr_data(io_wr_data),
      .io_rd_addr(io_rd_addr),
      .io_rd_data(io_rd_data),
      .frame_tick(frame_tick),
      .synced(synced),
      .frame_err(frame_err)
`ifdef AUDIO_IO_ERR_CNT_EN
      ,
      .err_count(err_count)
`endif
   );

   // Core clock, 8x the bit clock.
   always #5 clk = ~clk;

   // Fixed DAC samples held in the output half of io memory.
   function automatic logic [IO_WIDTH-1:0] out_sample(input int addr);
      case (addr)
         8:       return 24'hC00003;
         9:       return 24'h800001;
         10:      return 24'h5A5A5A;
         11:      return 24'h000001;
         12:      return 24'hFFFFFF;
         13:      return 24'h0F0F0F;
         14:      return 24'h123456;
         15:      return 24'h7FFFFE;
         default: return 24'h000000;
      endcase
   endfunction

   // ADC sample for frame f, slot s.
   function automatic logic [IO_WIDTH-1:0] in_sample(input int f, input int s);
      if (f == 1 && s == 0) return 24'hA5A5A5;
      if (f == 1 && s == 3) return 24'h123456;
      return {4'(f), 4'(s), 8'h69, 4'(~s), 4'(f)};
   endfunction

   // io memory read port: registered, data one clk after the address.
   always @(posedge clk) begin
      io_rd_data <= out_sample(int'(io_rd_addr));
   end

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Write-port monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && io_wr_en === 1'b1) begin
         wr_item_t exp_item;
         wr_count++;
         if (wr_q.size() == 0) begin
            check_output("wr_unexpected", {IO_ADDR_WIDTH'(0), io_wr_data}, 32'hFFFF_FFFF);
         end else begin
            exp_item = wr_q.pop_front();
            check_output("wr_addr", 32'(io_wr_addr), 32'(exp_item.addr));
            check_output("wr_data", 32'(io_wr_data), 32'(exp_item.data));
         end
      end
   end

   // DAC monitor: each captured slot word is compared with the oldest expectation.
   always @(negedge clk) begin
      if (dac_seen_q.size() > 0) begin
         logic [31:0] seen;
         seen = dac_seen_q.pop_front();
         if (dac_exp_q.size() == 0) begin
            check_output("dac_unexpected", seen, 32'hFFFF_FFFF);
         end else begin
            check_output("dac_word", seen, dac_exp_q.pop_front());
         end
      end
   end

   // Pulse counters for frame_tick and frame_err.
   always @(negedge clk) begin
      if (frame_tick === 1'b1) tick_count++;
      if (frame_err === 1'b1) err_pulses++;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One bclk period: data changes with the falling edge; sdout captured just before the rise.
   task automatic drive_bit(input logic lr, input logic sd, output logic dac);
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdin  = sd;
      #HALF_BCLK;
      dac      = i2s_sdout;
      i2s_bclk = 1'b1;
      #HALF_BCLK;
   endtask

   // One frame (optionally stopped at stop_slot/stop_bit), queuing expected writes and DAC words.
   task automatic apply_stimulus(input int f, input int stop_slot, input int stop_bit,
                                 input logic [7:0] dac_mask, input bit slot0_zero);
      logic                dac;
      logic [31:0]         word;
      logic [IO_WIDTH-1:0] smp;
      drive_bit(1'b0, 1'b1, dac);
      for (int s = 0; s < NUM_CHANNELS; s++) begin
         smp = in_sample(f, s);
         if (s < stop_slot) begin
            wr_q.push_back('{addr: IO_ADDR_WIDTH'(IN_BASE + s), data: smp});
            if (dac_mask[s]) begin
               dac_exp_q.push_back((s == 0 && slot0_zero) ? 32'h0 : {out_sample(OUT_BASE + s), 8'h00});
            end
         end
         word = '0;
         for (int b = 0; b < SLOT_WIDTH; b++) begin
            if (s == stop_slot && b == stop_bit) return;
            drive_bit((s >= NUM_CHANNELS / 2) ? 1'b1 : 1'b0,
                      (b < IO_WIDTH) ? smp[IO_WIDTH - 1 - b] : 1'b1, dac);
            word = {word[30:0], dac};
         end
         if (dac_mask[s]) dac_seen_q.push_back(word);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_sdout"}, 32'(i2s_sdout), 32'h0);
      check_output({tag, "_wr_en"}, 32'(io_wr_en), 32'h0);
      check_output({tag, "_wr_addr"}, 32'(io_wr_addr), 32'h0);
      check_output({tag, "_wr_data"}, 32'(io_wr_data), 32'h0);
      check_output({tag, "_rd_addr"}, 32'(io_rd_addr), 32'(OUT_BASE));
      check_output({tag, "_tick"}, 32'(frame_tick), 32'h0);
      check_output({tag, "_synced"}, 32'(synced), 32'h0);
      check_output({tag, "_err"}, 32'(frame_err), 32'h0);
`ifdef AUDIO_IO_ERR_CNT_EN
      check_output({tag, "_err_count"}, 32'(err_count), 32'h0);
`endif
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   // Main directed sequence.
   initial begin
      logic dac;
      int   wr_base;
      reset_n   = 1'b0;
      i2s_bclk  = 1'b0;
      i2s_lrclk = 1'b1;
      i2s_sdin  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, dac);
      settle();
      check_output("pre_synced", 32'(synced), 32'h0);
      check_output("pre_ticks", 32'(tick_count), 32'h0);

      $display("[TB] frame 1: first sync, slot 0 must be silent");
      wr_base = wr_count;
      apply_stimulus(1, NUM_CHANNELS, 0, 8'hFF, 1'b1);
      settle();
      check_output("f1_ticks", 32'(tick_count), 32'd1);
      check_output("f1_synced", 32'(synced), 32'h1);
      check_output("f1_writes", 32'(wr_count - wr_base), 32'd8);

      $display("[TB] frame 2: prefetched DAC samples in every slot");
      wr_base = wr_count;
      apply_stimulus(2, NUM_CHANNELS, 0, 8'hFF, 1'b0);
      settle();
      check_output("f2_ticks", 32'(tick_count), 32'd2);
      check_output("f2_writes", 32'(wr_count - wr_base), 32'd8);
      check_output("f2_errs", 32'(err_pulses), 32'd0);

      $display("[TB] frame 3 cut at slot 5 bit 10, frame 4 complete");
      wr_base = wr_count;
      apply_stimulus(3, 5, 10, 8'h1F, 1'b0);
      apply_stimulus(4, NUM_CHANNELS, 0, 8'hFE, 1'b0);
      settle();
      check_output("cut_errs", 32'(err_pulses), 32'd1);
      check_output("cut_writes", 32'(wr_count - wr_base), 32'd13);

      $display("[TB] missing frame start after a full frame");
      drive_bit(1'b1, 1'b0, dac);
      settle();
      check_output("late_errs", 32'(err_pulses), 32'd2);
      wr_base = wr_count;
      apply_stimulus(5, NUM_CHANNELS, 0, 8'hFF, 1'b0);
      settle();
      check_output("f5_writes", 32'(wr_count - wr_base), 32'd8);
      check_output("f5_errs", 32'(err_pulses), 32'd2);

      $display("[TB] frame 6 cut at slot 6 bit 3, frame 7 complete");
      apply_stimulus(6, 6, 3, 8'h3F, 1'b0);
      apply_stimulus(7, NUM_CHANNELS, 0, 8'hFE, 1'b0);
      settle();
      check_output("third_errs", 32'(err_pulses), 32'd3);
`ifdef AUDIO_IO_ERR_CNT_EN
      check_output("err_count_3", 32'(err_count), 32'd3);
`endif

      $display("[TB] reset in the middle of slot 4");
      apply_stimulus(8, 4, 12, 8'h0F, 1'b0);
      settle();
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_values("midrst");
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, dac);
      settle();
      check_output("resync_wait", 32'(synced), 32'h0);
      wr_base = wr_count;
      apply_stimulus(9, NUM_CHANNELS, 0, 8'hFF, 1'b1);
      settle();
      check_output("resync_synced", 32'(synced), 32'h1);
      check_output("resync_writes", 32'(wr_count - wr_base), 32'd8);
      check_output("resync_errs", 32'(err_pulses), 32'd3);
`ifdef AUDIO_IO_ERR_CNT_EN
      check_output("err_count_rst", 32'(err_count), 32'd0);
`endif

      repeat (8) @(negedge clk);
      check_output("wr_q_left", 32'(wr_q.size()), 32'd0);
      check_output("dac_q_left", 32'(dac_exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
